// File: rtl/trojan_trigger_seq.sv
// Plaintext-sequence trigger: four matching loads in order arm Tj_Trig, which
// then stays high either until reset (ARM_LOADS==0) or for ARM_LOADS further loads.
module trojan_trigger_seq #(
    parameter logic [127:0] P1        = 128'h00112233445566778899aabbccddeeff,
    parameter logic [127:0] P2        = 128'h3243f6a8885a308d313198a2e0370734,
    parameter logic [127:0] P3        = 128'h00000000000000000000000000000000,
    parameter logic [127:0] P4        = 128'hffffffffffffffffffffffffffffffff,
    parameter logic [7:0]   ARM_LOADS = 8'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [127:0] state,
    output logic         Tj_Trig,
    output logic [2:0]   trig_state,
    output logic [7:0]   arm_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S2    = 3'd2,
        S3    = 3'd3,
        ARMED = 3'd4
    } fsm_t;

    fsm_t       cur_state;
    fsm_t       nxt_state;
    logic [7:0] cnt_nxt;
    logic       hit1, hit2, hit3, hit4;

    assign hit1 = (state == P1);
    assign hit2 = (state == P2);
    assign hit3 = (state == P3);
    assign hit4 = (state == P4);

    assign trig_state = cur_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= IDLE;
            Tj_Trig   <= 1'b0;
            arm_cnt   <= 8'd0;
        end else begin
            cur_state <= nxt_state;
            Tj_Trig   <= (nxt_state == ARMED);
            arm_cnt   <= cnt_nxt;
        end
    end

    // A mismatch mid-sequence still restarts at S1 when the load is P1 itself.
    always_comb begin
        nxt_state = cur_state;
        cnt_nxt   = arm_cnt;
        case (cur_state)
            IDLE: begin
                if (load && hit1) nxt_state = S1;
            end
            S1: begin
                if (load) nxt_state = hit2 ? S2 : (hit1 ? S1 : IDLE);
            end
            S2: begin
                if (load) nxt_state = hit3 ? S3 : (hit1 ? S1 : IDLE);
            end
            S3: begin
                if (load) begin
                    if (hit4) begin
                        nxt_state = ARMED;
                        cnt_nxt   = ARM_LOADS;
                    end else begin
                        nxt_state = hit1 ? S1 : IDLE;
                    end
                end
            end
            ARMED: begin
                // Plaintexts are ignored here; only the load count matters.
                if (load && (ARM_LOADS != 8'd0)) begin
                    if (arm_cnt <= 8'd1) nxt_state = IDLE;
                    else                 cnt_nxt   = arm_cnt - 8'd1;
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (nxt_state != ARMED) cnt_nxt = 8'd0;
    end

endmodule
